// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and width limit.
package serial_adder_pkg;

    // Largest operand width the datapath is meant to be built with.
    localparam int SA_WIDTH_MAX = 32;

    // Controller states; encodings fixed so they match external documentation.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fadder.sv
// Single full-adder cell with active-low operand/carry inputs and active-high outputs.
module fadder (
    input  logic nA,
    input  logic nB,
    input  logic nCin,
    output logic S,
    output logic Cout
);

    logic w_a;
    logic w_b;
    logic w_c;

    assign w_a = ~nA;
    assign w_b = ~nB;
    assign w_c = ~nCin;

    // Plain full-adder equations on the recovered true-polarity bits.
    always_comb begin
        S    = w_a ^ w_b ^ w_c;
        Cout = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    end

endmodule : fadder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes one bit pair per clock,
// LSB first, with the ripple carry held in a flip-flop between cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Only WIDTH-1 partial bits are stored; the final sum bit comes straight
    // from the cell on the completing cycle.
    logic [WIDTH-2:0] r_acc_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_wide;

    // The cell sees the current LSBs and the held carry, inverted for its active-low inputs.
    fadder u_fadder (
        .nA   (~r_a_sh[0]),
        .nB   (~r_b_sh[0]),
        .nCin (~r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign w_acc_wide = {w_s, r_acc_sh};

    // Controller, shift registers, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_acc_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    r_acc_sh <= w_acc_wide[WIDTH-1:1];
                    r_carry  <= w_cout;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_sum   <= w_acc_wide;
                        r_cout  <= w_cout;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {cout,sum} and completion edge are
// queued when a start is driven and compared when done is seen.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [WIDTH:0] exp_q[$];
    int             lat_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest queued request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                logic [WIDTH:0] e;
                int             l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
                check("cout", 64'(cout), 64'(e[WIDTH]));
                check("done_edge", 64'(cyc), 64'(l));
                check("busy_at_done", 64'(busy), 64'd0);
                $display("done: sum=%02h cout=%0b at cycle %0d", sum, cout, cyc);
            end
        end
    end

    // Queue expectation for a start that the next rising edge will accept.
    task automatic push_exp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic tc);
        logic [WIDTH:0] s;
        s = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
        exp_q.push_back(s);
        lat_q.push_back(cyc + 1 + WIDTH);
        $display("start: a=%02h b=%02h cin=%0b expect sum=%02h cout=%0b",
                 ta, tb, tc, s[WIDTH-1:0], s[WIDTH]);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check(tag, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            lat_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc);
        @(posedge clk);
        #1;
        a = ta; b = tb; cin = tc; start = 1'b1;
        push_exp(ta, tb, tc);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        check("busy_after_accept", 64'(busy), 64'd1);
        wait_drain("op_timeout");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;

        // Idle with start low: nothing moves.
        repeat (20) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_sum", 64'({cout, sum}), 64'd0);

        run_op(8'h64, 8'h1B, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1);

        // Start during ADD is ignored; start in the DONE cycle is accepted.
        @(posedge clk);
        #1;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        push_exp(8'h01, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_ignore", 64'(busy), 64'd1);
        begin
            int n;
            n = 0;
            while (done !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("done_seen", 64'(done), 64'd1);
        end
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        push_exp(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_b2b", 64'(busy), 64'd1);
        wait_drain("b2b_timeout");

        // Reset mid-add: abandoned, no done pulse, outputs cleared.
        @(posedge clk);
        #1;
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        $display("start: a=f0 b=0f (to be abandoned by reset)");
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_done_sum", 64'({cout, sum}), 64'd0);
        run_op(8'h03, 8'h04, 1'b0);

        // A few random operations.
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder
